fetch_unit: RTL and testbench

Instruction fetch stage of the CPU. It holds the program counter, issues one instruction-memory read at a time, and presents the fetched instruction with its PC to decode through a valid/ready handshake. The redirect target is the 32-bit output of the upstream `MUX32_2_1`, which selects between the branch target and the jump target. `fetch_unit` is the downstream consumer of that mux.

---
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It holds the program counter, issues at most one
// instruction-memory read at a time, and hands the fetched word and its PC to
// decode through a registered valid/ready buffer. A redirect (taken branch or
// jump) replaces the PC with the word-aligned TARGET from the upstream
// MUX32_2_1. A redirect also squashes whatever is in flight or buffered.
//
// Parameters:
//   RESET_PC     PC loaded on reset (bits [1:0] must be zero)
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset, dominant over all inputs
//   REDIRECT     load the PC from TARGET this cycle
//   TARGET       redirect address, low two bits ignored
//   IMEM_REQ     read request (combinational)
//   IMEM_ADDR    read address, always the current PC
//   IMEM_GNT     memory accepts the request in the same cycle
//   IMEM_RVALID  read data valid, at least one cycle after the grant
//   IMEM_RDATA   instruction word returned by memory
//   INST_VALID   output buffer holds an instruction (registered)
//   INST         buffered instruction (registered)
//   INST_PC      PC of the buffered instruction (registered)
//   INST_READY   decode accepts INST this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REDIRECT,
    input  logic [31:0] TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        INST_VALID,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    input  logic        INST_READY
);

    // IDLE : no request outstanding, free to issue
    // WAIT : one request outstanding, its data will be kept
    // DROP : one request outstanding, but a redirect made its data stale
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] fetchPc_q,   fetchPc_d;
    logic        instValid_q, instValid_d;
    logic [31:0] inst_q,      inst_d;
    logic [31:0] instPc_q,    instPc_d;

    logic        issue;
    logic        capture;
    logic [31:0] redirectPc;

    // Only one request may be outstanding, so a new one is allowed only from
    // IDLE. A redirect suppresses the request because the PC is about to
    // change. The buffer must either be empty or be drained this cycle, which
    // is what guarantees it is empty by the time the response returns.
    assign IMEM_REQ  = !RST && (state_q == IDLE) && !REDIRECT
                       && (!instValid_q || INST_READY);
    assign IMEM_ADDR = pc_q;

    assign issue = IMEM_REQ && IMEM_GNT;

    // Response data is kept only for a live request with no redirect in the
    // same cycle; in DROP the returning data belongs to the abandoned path.
    assign capture = (state_q == WAIT) && IMEM_RVALID && !REDIRECT;

    // Masking instead of slicing clears the low bits while still consuming
    // the whole TARGET bus.
    assign redirectPc = TARGET & 32'hFFFF_FFFC;

    assign INST_VALID = instValid_q;
    assign INST       = inst_q;
    assign INST_PC    = instPc_q;

    // Program counter: a redirect always wins over the sequential increment.
    // The increment wraps naturally at 32 bits (0xFFFF_FFFC + 4 = 0).
    always_comb begin
        pc_d      = pc_q;
        fetchPc_d = fetchPc_q;
        if (REDIRECT) begin
            pc_d = redirectPc;
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
        if (issue) begin
            fetchPc_d = pc_q;
        end
    end

    // Request tracking. RVALID seen in IDLE has no request to belong to and
    // is ignored. A redirect while waiting turns the outstanding request
    // stale; the FSM still has to see its RVALID before issuing again so the
    // memory never has two requests in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (IMEM_RVALID) begin
                    state_d = IDLE;
                end else if (REDIRECT) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (IMEM_RVALID) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output buffer. A redirect empties it (a simultaneous handshake is
    // squashed; decode discards its own wrong-path copy). Otherwise a
    // capture overrides a consume in the same cycle. INST and INST_PC only
    // change on capture so they hold while the buffer is empty.
    always_comb begin
        instValid_d = instValid_q;
        inst_d      = inst_q;
        instPc_d    = instPc_q;
        if (REDIRECT) begin
            instValid_d = 1'b0;
        end else if (capture) begin
            instValid_d = 1'b1;
            inst_d      = IMEM_RDATA;
            instPc_d    = fetchPc_q;
        end else if (instValid_q && INST_READY) begin
            instValid_d = 1'b0;
        end
    end

    // State registers with synchronous reset. Reset abandons any request in
    // flight; its late RVALID then lands in IDLE and is ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            fetchPc_q   <= 32'h0000_0000;
            instValid_q <= 1'b0;
            inst_q      <= 32'h0000_0000;
            instPc_q    <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetchPc_q   <= fetchPc_d;
            instValid_q <= instValid_d;
            inst_q      <= inst_d;
            instPc_q    <= instPc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed scenarios followed by a randomized run, all compared every cycle
// against a transaction-level reference model: the model tracks "is a
// request outstanding", "is its data stale", the PC and the output buffer,
// and derives the expected outputs from those.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        CLK;
    logic        RST;
    logic        REDIRECT;
    logic [31:0] TARGET;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        INST_VALID;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_READY;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] mPc;
    logic        mPending;
    logic        mStale;
    logic [31:0] mReqAddr;
    logic        mValid;
    logic [31:0] mInst;
    logic [31:0] mInstPc;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REDIRECT    (REDIRECT),
        .TARGET      (TARGET),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .INST_VALID  (INST_VALID),
        .INST        (INST),
        .INST_PC     (INST_PC),
        .INST_READY  (INST_READY)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare every output at the falling edge
    // against the model, then advance the model to what the rising edge
    // should produce and step past that edge.
    task automatic applyStimulus(input logic rst, input logic redirect, input logic [31:0] target,
                                 input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                 input logic ready);
        logic req;
        logic keep;
        RST         = rst;
        REDIRECT    = redirect;
        TARGET      = target;
        IMEM_GNT    = gnt;
        IMEM_RVALID = rvalid;
        IMEM_RDATA  = rdata;
        INST_READY  = ready;
        @(negedge CLK);
        req = !rst && !mPending && !redirect && (!mValid || ready);
        checkOutput("req",       {31'b0, IMEM_REQ},   {31'b0, req});
        checkOutput("addr",      IMEM_ADDR,           mPc);
        checkOutput("instValid", {31'b0, INST_VALID}, {31'b0, mValid});
        checkOutput("inst",      INST,                mInst);
        checkOutput("instPc",    INST_PC,             mInstPc);
        if (rst) begin
            mPc      = RESET_PC;
            mPending = 1'b0;
            mStale   = 1'b0;
            mReqAddr = 32'h0;
            mValid   = 1'b0;
            mInst    = 32'h0;
            mInstPc  = 32'h0;
        end else begin
            keep = mPending && rvalid && !mStale && !redirect;
            if (redirect) begin
                mValid = 1'b0;
            end else if (keep) begin
                mValid  = 1'b1;
                mInst   = rdata;
                mInstPc = mReqAddr;
            end else if (mValid && ready) begin
                mValid = 1'b0;
            end
            if (mPending && rvalid) begin
                mPending = 1'b0;
            end else if (mPending && redirect) begin
                mStale = 1'b1;
            end
            if (req && gnt) begin
                mPending = 1'b1;
                mStale   = 1'b0;
                mReqAddr = mPc;
            end
            if (redirect) begin
                mPc = target & 32'hFFFF_FFFC;
            end else if (req && gnt) begin
                mPc = mPc + 32'd4;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; REDIRECT = 1'b0; TARGET = 32'h0; IMEM_GNT = 1'b0;
        IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0; INST_READY = 1'b0;
        mPc = RESET_PC; mPending = 1'b0; mStale = 1'b0; mReqAddr = 32'h0;
        mValid = 1'b0; mInst = 32'h0; mInstPc = 32'h0;
        @(posedge CLK);
        #1;

        // Reset held, inputs active: request must stay low
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 1);
        applyStimulus(1, 1, 32'h500, 1, 1, 32'h1234, 1);
        checkOutput("rstAddr", IMEM_ADDR, RESET_PC);

        // Sequential fetch: grant always, data one cycle after grant
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 32'h0, 1, mPending, $urandom, 1);
        end
        checkOutput("seqLastPc", INST_PC, 32'h0000_0108);

        // Decode stall with 0xDEADBEEF buffered
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 0);
            checkOutput("stallInst", INST, 32'hDEAD_BEEF);
            checkOutput("stallReq", {31'b0, IMEM_REQ}, 32'h0);
        end
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 1);

        // Redirect while waiting: stale data dropped, next fetch at 0x400
        applyStimulus(0, 1, 32'h0000_0200, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        applyStimulus(0, 1, 32'h0000_0403, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 0, 1, 32'hBAD0_BAD0, 1);
        checkOutput("dropValid", {31'b0, INST_VALID}, 32'h0);
        checkOutput("dropAddr", IMEM_ADDR, 32'h0000_0400);
        checkOutput("dropReq", {31'b0, IMEM_REQ}, 32'h1);

        // Redirect in the same cycle as RVALID
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        applyStimulus(0, 1, 32'h0000_0080, 0, 1, 32'h5555_5555, 1);
        checkOutput("collValid", {31'b0, INST_VALID}, 32'h0);
        checkOutput("collAddr", IMEM_ADDR, 32'h0000_0080);

        // Redirect during a handshake on a buffered instruction
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 0, 1, 32'h1111_1111, 0);
        applyStimulus(0, 1, 32'h0000_1000, 1, 0, 32'h0, 1);
        checkOutput("squashValid", {31'b0, INST_VALID}, 32'h0);
        checkOutput("squashAddr", IMEM_ADDR, 32'h0000_1000);
        checkOutput("squashPcHold", INST_PC, 32'h0000_0080);

        // Slow memory at the top of the address space
        applyStimulus(0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 1);
            checkOutput("slowAddr", IMEM_ADDR, 32'hFFFF_FFFC);
        end
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        end
        applyStimulus(0, 0, 32'h0, 0, 1, 32'h0000_C0DE, 1);
        checkOutput("wrapAddr", IMEM_ADDR, 32'h0000_0000);
        checkOutput("wrapInstPc", INST_PC, 32'hFFFF_FFFC);
        checkOutput("wrapInst", INST, 32'h0000_C0DE);

        // Reset while waiting, then a stale RVALID right after
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 1);
        checkOutput("midRstValid", {31'b0, INST_VALID}, 32'h0);
        checkOutput("midRstAddr", IMEM_ADDR, RESET_PC);
        applyStimulus(0, 0, 32'h0, 0, 1, 32'hBAD1_BAD1, 1);
        checkOutput("staleValid", {31'b0, INST_VALID}, 32'h0);
        checkOutput("staleAddr", IMEM_ADDR, RESET_PC);

        // Randomized traffic; data only returns for an outstanding request
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 64) == 0,
                          ($urandom % 8) == 0,
                          $urandom,
                          ($urandom % 2) == 0,
                          mPending && (($urandom % 2) == 0),
                          $urandom,
                          ($urandom % 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
